// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_pkg
//  Purpose  : Shared definitions for the CPU memory bus: command encodings
//             (also used by the CPU), I/O register addresses and the
//             read-source select type used by the read pipeline.
//  Revision : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

  // CPU memory-port command encodings; 2'b11 is illegal.
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // I/O register word addresses (I/O space is mem_addr[8] == 1).
  localparam logic [8:0] ADDR_LED   = 9'h100;
  localparam logic [8:0] ADDR_SW    = 9'h140;
  localparam logic [8:0] ADDR_TIMER = 9'h180;

  // Source of the data returned one cycle after a READ.
  typedef enum logic {
    RD_RAM = 1'b0,
    RD_IO  = 1'b1
  } rd_sel_e;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module   : sync2
//  Purpose  : Parameterized-width two-flop synchronizer for slow, quasi-static
//             asynchronous inputs such as board switches. Bits are synchronized
//             independently; no multi-bit coherence is implied.
//  Ports    : clk   - system clock, rising edge
//             reset - synchronous active-high reset, clears both stages
//             d     - asynchronous input
//             q     - synchronized output (2 edges of latency)
//  Revision : 1.0  initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_bus_ctrl
//  Purpose  : Memory-bus fabric between the CPU memory port and a 256-word
//             synchronous RAM plus board I/O (LED register, switch port,
//             free-running cycle timer). Every read returns data exactly one
//             cycle after the READ command, from RAM or I/O alike.
//  Ports    : clk, reset           - clock / synchronous active-high reset
//             mem_cmd, mem_addr,
//             mem_wdata            - CPU command, word address, write data
//             mem_rdata            - read data, valid the cycle after a READ
//             ram_raddr/ram_waddr,
//             ram_we, ram_wdata    - combinational RAM control
//             ram_dout             - RAM registered read data
//             sw                   - raw asynchronous board switches
//             ledr                 - LED register
//             bus_err              - sticky error flag, cleared by reset only
//  Revision : 1.0  initial release
// ============================================================================
module mmio_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RAM_AW  = 8,
  parameter int TIMER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [8:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [RAM_AW-1:0] ram_raddr,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [9:0]        sw,
  output logic [7:0]        ledr,
  output logic              bus_err
);

  logic [9:0]         w_sw_sync;
  logic               w_is_ram;
  logic               w_rd;
  logic               w_wr;
  logic               w_illegal;
  logic               w_unmapped;
  logic               w_err;
  logic [DATA_W-1:0]  w_io_rdata;
  logic [1:0]         w_unused_sw_hi;

  rd_sel_e            r_rd_sel;
  logic [DATA_W-1:0]  r_io_rdata;
  logic [7:0]         r_ledr;
  logic [TIMER_W-1:0] r_timer;
  logic               r_bus_err;

  sync2 #(.WIDTH(10)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (w_sw_sync)
  );

  // Only the low byte of the switches is readable.
  assign w_unused_sw_hi = w_sw_sync[9:8];

  // RAM is a straight pass-through; the write enable is combinational, so a
  // RAM write still lands in a cycle where reset is asserted.
  assign w_is_ram  = (mem_addr[8] == 1'b0);
  assign ram_raddr = mem_addr[RAM_AW-1:0];
  assign ram_waddr = mem_addr[RAM_AW-1:0];
  assign ram_wdata = mem_wdata;
  assign ram_we    = w_wr && w_is_ram;

  always_comb begin
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_illegal = 1'b0;
    case (mem_cmd)
      MEM_NONE:  ;
      MEM_READ:  w_rd = 1'b1;
      MEM_WRITE: w_wr = 1'b1;
      default:   w_illegal = 1'b1;
    endcase
  end

  // I/O read mux, sampled with pre-edge register values.
  always_comb begin
    w_io_rdata = '0;
    w_unmapped = 1'b0;
    case (mem_addr)
      ADDR_LED:   w_io_rdata = DATA_W'(r_ledr);
      ADDR_SW:    w_io_rdata = DATA_W'(w_sw_sync[7:0]);
      ADDR_TIMER: w_io_rdata = DATA_W'(r_timer);
      default:    w_unmapped = !w_is_ram;
    endcase
  end

  assign w_err = w_illegal
              || (w_wr && (mem_addr == ADDR_SW))
              || ((w_rd || w_wr) && w_unmapped);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_sel   <= RD_IO;
      r_io_rdata <= '0;
      r_ledr     <= '0;
      r_timer    <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_rd) begin
        r_rd_sel <= w_is_ram ? RD_RAM : RD_IO;
        if (!w_is_ram) begin
          r_io_rdata <= w_io_rdata;
        end
      end

      if (w_wr && (mem_addr == ADDR_LED)) begin
        r_ledr <= mem_wdata[7:0];
      end

      // A timer write wins over the free-running increment.
      if (w_wr && (mem_addr == ADDR_TIMER)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_err) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign mem_rdata = (r_rd_sel == RD_RAM) ? ram_dout : r_io_rdata;
  assign ledr      = r_ledr;
  assign bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_bus_ctrl
//  Purpose  : Directed self-checking bench for mmio_bus_ctrl with a
//             behavioural 256x16 synchronous RAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmio_bus_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [7:0]  ram_raddr;
  logic [7:0]  ram_waddr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_dout;
  logic [9:0]  sw;
  logic [7:0]  ledr;
  logic        bus_err;

  int n_tests;
  int n_fail;

  logic [15:0] ram_mem [0:255];

  mmio_bus_ctrl #(.DATA_W(16), .RAM_AW(8), .TIMER_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ram_raddr (ram_raddr),
    .ram_waddr (ram_waddr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_dout  (ram_dout),
    .sw        (sw),
    .ledr      (ledr),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, registered read data.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    ram_dout <= ram_mem[ram_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    mem_cmd   = cmd;
    mem_addr  = addr;
    mem_wdata = data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 9'h000, 16'h0000);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(2'b10, 9'h000, 16'hD840);   // RAM write lands despite reset
    tick();
    drive(2'b10, 9'h100, 16'h00FF);   // LED write dropped by reset
    tick();
    reset = 1'b0;
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", mem_rdata, 16'h0000); end
    n_tests++; if (ledr !== 8'h00) begin n_fail++; $display("FAIL reset_ledr: got %h want %h", ledr, 8'h00); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want %b", bus_err, 1'b0); end
    drive(2'b01, 9'h000, 16'h0000);
    tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (mem_rdata !== 16'hD840) begin n_fail++; $display("FAIL reset_ram_read: got %h want %h", mem_rdata, 16'hD840); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_ram_read_err: got %b want %b", bus_err, 1'b0); end
  endtask

  task automatic test_led();
    drive(2'b10, 9'h100, 16'h12A5);
    #1;
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL led_write_ram_we: got %b want %b", ram_we, 1'b0); end
    tick();
    n_tests++; if (ledr !== 8'hA5) begin n_fail++; $display("FAIL led_write: got %h want %h", ledr, 8'hA5); end
    drive(2'b01, 9'h100, 16'h0000);
    #1;
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL led_read_ram_we: got %b want %b", ram_we, 1'b0); end
    tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (mem_rdata !== 16'h00A5) begin n_fail++; $display("FAIL led_read: got %h want %h", mem_rdata, 16'h00A5); end
    tick();
    n_tests++; if (mem_rdata !== 16'h00A5) begin n_fail++; $display("FAIL led_read_hold: got %h want %h", mem_rdata, 16'h00A5); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL led_bus_err: got %b want %b", bus_err, 1'b0); end
  endtask

  task automatic test_sw();
    sw = 10'h3C3;
    drive(2'b00, 9'h000, 16'h0000);
    tick();                            // first sync stage
    drive(2'b01, 9'h140, 16'h0000);
    tick();                            // sync output updates on this edge
    n_tests++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL sw_read_early: got %h want %h", mem_rdata, 16'h0000); end
    tick();                            // third edge captures the new value
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (mem_rdata !== 16'h00C3) begin n_fail++; $display("FAIL sw_read_late: got %h want %h", mem_rdata, 16'h00C3); end
  endtask

  task automatic test_timer();
    do_reset();
    repeat (10) tick();
    drive(2'b01, 9'h180, 16'h0000);
    tick();
    n_tests++; if (mem_rdata !== 16'h000A) begin n_fail++; $display("FAIL timer_count: got %h want %h", mem_rdata, 16'h000A); end
    drive(2'b10, 9'h180, 16'hBEEF);
    tick();
    drive(2'b01, 9'h180, 16'h0000);
    tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL timer_clear: got %h want %h", mem_rdata, 16'h0000); end
    // Timer is now 1; run it up to 0xFFFF and watch it wrap.
    repeat (16'hFFFE) tick();
    drive(2'b01, 9'h180, 16'h0000);
    tick();
    n_tests++; if (mem_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL timer_max: got %h want %h", mem_rdata, 16'hFFFF); end
    tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL timer_wrap: got %h want %h", mem_rdata, 16'h0000); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timer_bus_err: got %b want %b", bus_err, 1'b0); end
  endtask

  task automatic test_errors();
    // Each error source on its own.
    do_reset();
    drive(2'b10, 9'h140, 16'hFFFF);
    #1;
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL err_sw_write_ram_we: got %b want %b", ram_we, 1'b0); end
    tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_sw_write: got %b want %b", bus_err, 1'b1); end
    do_reset();
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear: got %b want %b", bus_err, 1'b0); end
    drive(2'b01, 9'h1C0, 16'h0000);
    tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_unmapped_read: got %b want %b", bus_err, 1'b1); end
    do_reset();
    drive(2'b11, 9'h040, 16'h5555);
    #1;
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL err_illegal_ram_we: got %b want %b", ram_we, 1'b0); end
    tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_illegal_cmd: got %b want %b", bus_err, 1'b1); end

    // Combined sequence: sticky flag, no side effects.
    do_reset();
    drive(2'b10, 9'h040, 16'hBEEF); tick();
    drive(2'b10, 9'h100, 16'h005A); tick();
    drive(2'b10, 9'h140, 16'h00FF); tick();
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_seq_first: got %b want %b", bus_err, 1'b1); end
    n_tests++; if (ledr !== 8'h5A) begin n_fail++; $display("FAIL err_seq_ledr: got %h want %h", ledr, 8'h5A); end
    drive(2'b01, 9'h100, 16'h0000); tick();
    n_tests++; if (mem_rdata !== 16'h005A) begin n_fail++; $display("FAIL err_seq_led_read: got %h want %h", mem_rdata, 16'h005A); end
    drive(2'b11, 9'h100, 16'h00FF); tick();
    n_tests++; if (mem_rdata !== 16'h005A) begin n_fail++; $display("FAIL err_illegal_hold: got %h want %h", mem_rdata, 16'h005A); end
    n_tests++; if (ledr !== 8'h5A) begin n_fail++; $display("FAIL err_illegal_ledr: got %h want %h", ledr, 8'h5A); end
    drive(2'b01, 9'h1C0, 16'h0000); tick();
    n_tests++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL err_unmapped_rdata: got %h want %h", mem_rdata, 16'h0000); end
    drive(2'b01, 9'h040, 16'h0000); tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL err_ram_intact: got %h want %h", mem_rdata, 16'hBEEF); end
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want %b", bus_err, 1'b1); end
    do_reset();
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_final_clear: got %b want %b", bus_err, 1'b0); end
  endtask

  task automatic test_back_to_back();
    drive(2'b10, 9'h005, 16'h1234); tick();
    drive(2'b10, 9'h100, 16'h007E); tick();
    drive(2'b01, 9'h005, 16'h0000); tick();
    n_tests++; if (mem_rdata !== 16'h1234) begin n_fail++; $display("FAIL b2b_first: got %h want %h", mem_rdata, 16'h1234); end
    drive(2'b01, 9'h100, 16'h0000); tick();
    n_tests++; if (mem_rdata !== 16'h007E) begin n_fail++; $display("FAIL b2b_second: got %h want %h", mem_rdata, 16'h007E); end
    drive(2'b01, 9'h000, 16'h0000); tick();
    drive(2'b00, 9'h000, 16'h0000);
    n_tests++; if (mem_rdata !== 16'hD840) begin n_fail++; $display("FAIL b2b_third: got %h want %h", mem_rdata, 16'hD840); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    sw      = 10'h000;
    drive(2'b00, 9'h000, 16'h0000);
    #1;
    test_reset();
    test_led();
    test_sw();
    test_timer();
    test_errors();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
